dl_chain: RTL and testbench

Parametrised clocked delay chain for the Gowin primitive simulation library. It generalises the single-bit, level-sensitive, enable-gated storage cell into a WIDTH-bit, DEPTH-stage, edge-triggered shift chain. Each stage has INIT preload, a shared clock enable, a selectable output tap, fill/valid tracking and a synchronous flush. It models shift-register-style delay primitives and must behave identically under Verilator and event-driven simulators.

---
 rtl/gowin_prim_pkg.sv | 18 +
 rtl/dl_stage.sv | 35 +++
 rtl/dl_chain.sv | 85 ++++++++
 tb/tb_dl_chain.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gowin_prim_pkg.sv
// Shared definitions for the Gowin primitive simulation library:
// constant log2 helper and clock-enable polarity encodings.
package gowin_prim_pkg;

    localparam logic CE_ACTIVE_HIGH = 1'b1;
    localparam logic CE_ACTIVE_LOW  = 1'b0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dl_stage.sv
// One WIDTH-bit stage of the delay chain: edge-triggered register that
// loads on an active enable and returns to INIT on asynchronous reset.
module dl_stage #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             ce_act_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // An unknown enable falls through to hold rather than corrupting the stage.
    always_comb begin
        q_d = q_q;
        if (ce_act_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dl_chain.sv
// WIDTH-bit, DEPTH-stage clocked delay chain with selectable output tap,
// saturating fill tracking and synchronous flush of the fill count.
module dl_chain
    import gowin_prim_pkg::*;
#(
    parameter int               WIDTH  = 1,
    parameter int               DEPTH  = 16,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter logic             CE_POL = CE_ACTIVE_HIGH,
    localparam int              SEL_W  = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int              FILL_W = clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              CE,
    input  logic              FLUSH,
    input  logic [WIDTH-1:0]  D,
    input  logic [SEL_W-1:0]  SEL,
    output logic [WIDTH-1:0]  Q,
    output logic              QV,
    output logic [FILL_W-1:0] FILL
);

    localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] ONE_F    = FILL_W'(1);

    logic                ce_act;
    logic [WIDTH-1:0]    stage_q [DEPTH];
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic [SEL_W-1:0]    sel_c;

    always_comb begin
        ce_act = (CE == CE_POL);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] din;
        if (k == 0) begin : g_head
            assign din = D;
        end else begin : g_link
            assign din = stage_q[k-1];
        end

        dl_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .CLK      (CLK),
            .RESETN   (RESETN),
            .ce_act_i (ce_act),
            .d_i      (din),
            .q_o      (stage_q[k])
        );
    end

    // Flush wins over counting; a flush on a shifting edge leaves exactly the new sample valid.
    always_comb begin
        fill_d = fill_q;
        if (FLUSH) begin
            fill_d = ce_act ? ONE_F : '0;
        end else if (ce_act && (fill_q != DEPTH_F)) begin
            fill_d = fill_q + ONE_F;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Out-of-range taps clamp to the last stage.
    always_comb begin
        sel_c = (SEL > LAST_SEL) ? LAST_SEL : SEL;
    end

    assign Q    = stage_q[sel_c];
    assign QV   = (fill_q > FILL_W'(sel_c));
    assign FILL = fill_q;

endmodule

// File: tb/tb_dl_chain.sv
// Scoreboard bench for dl_chain: three instances (depth 4, depth 5 with a
// 3-bit tap, active-low enable) share stimulus and a history-based model.
module tb_dl_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       flush;
    logic [7:0] d;
    logic [2:0] sel3;
    logic [1:0] sel2;

    logic [7:0] q0, q1, q2;
    logic       qv0, qv1, qv2;
    logic [2:0] fill0, fill1, fill2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign sel2 = sel3[1:0];

    dl_chain #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5), .CE_POL(1'b1)) u_d4 (
        .CLK(clk), .RESETN(rst_n), .CE(ce), .FLUSH(flush), .D(d), .SEL(sel2),
        .Q(q0), .QV(qv0), .FILL(fill0));

    dl_chain #(.WIDTH(8), .DEPTH(5), .INIT(8'hA5), .CE_POL(1'b1)) u_d5 (
        .CLK(clk), .RESETN(rst_n), .CE(ce), .FLUSH(flush), .D(d), .SEL(sel3),
        .Q(q1), .QV(qv1), .FILL(fill1));

    dl_chain #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5), .CE_POL(1'b0)) u_pol0 (
        .CLK(clk), .RESETN(rst_n), .CE(ce), .FLUSH(flush), .D(d), .SEL(sel2),
        .Q(q2), .QV(qv2), .FILL(fill2));

    // Reference: hist[i][n] is the sample taken n enabled edges before the latest one.
    logic [7:0] hist [3][5];
    int         mfill [3];
    int         mdepth [3] = '{4, 5, 4};
    logic       mpol [3]   = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        int         inst;
        logic [7:0] q;
        logic       qv;
        int         fill;
    } exp_t;

    exp_t sb [$];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) hist[i][k] = 8'hA5;
            mfill[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic act;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                act = (ce == mpol[i]);
                if (act) begin
                    for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = d;
                end
                if (flush) mfill[i] = act ? 1 : 0;
                else if (act) mfill[i] = (mfill[i] + 1 > mdepth[i]) ? mdepth[i] : mfill[i] + 1;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int   sel;
        int   s;
        for (int i = 0; i < 3; i++) begin
            sel    = (i == 1) ? int'(sel3) : int'(sel2);
            s      = (sel > mdepth[i] - 1) ? mdepth[i] - 1 : sel;
            e.inst = i;
            e.q    = hist[i][s];
            e.qv   = (mfill[i] > s);
            e.fill = mfill[i];
            sb.push_back(e);
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic f,
                         input logic [7:0] dv, input logic [2:0] s);
        @(negedge clk);
        #1;
        rst_n = r; ce = c; flush = f; d = dv; sel3 = s;
        @(posedge clk);
        #1;
        model_edge();
        push_exp();
    endtask

    // Reset asserted between edges; the monitor checks at the following negedge.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        ce = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        model_edge();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] aq;
        logic       aqv;
        int         af;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.inst)
                    0:       begin aq = q0; aqv = qv0; af = int'(fill0); end
                    1:       begin aq = q1; aqv = qv1; af = int'(fill1); end
                    default: begin aq = q2; aqv = qv2; af = int'(fill2); end
                endcase
                checks++;
                if (aq !== e.q) begin
                    failures++;
                    $display("FAIL q inst=%0d sel=%0d actual=%h expected=%h t=%0t", e.inst, sel3, aq, e.q, $time);
                end
                checks++;
                if (aqv !== e.qv) begin
                    failures++;
                    $display("FAIL qv inst=%0d sel=%0d actual=%b expected=%b t=%0t", e.inst, sel3, aqv, e.qv, $time);
                end
                checks++;
                if (af != e.fill) begin
                    failures++;
                    $display("FAIL fill inst=%0d actual=%0d expected=%0d t=%0t", e.inst, af, e.fill, $time);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; ce = 1'b0; flush = 1'b0; d = 8'h00; sel3 = 3'd0;
        model_reset();

        for (int s = 0; s < 8; s++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'(s));

        cycle(1'b1, 1'b1, 1'b0, 8'h01, 3'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'h02, 3'd1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 3'd2);
        cycle(1'b1, 1'b1, 1'b0, 8'h03, 3'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'h04, 3'd0);
        for (int s = 0; s < 4; s++) cycle(1'b1, 1'b0, 1'b0, 8'hFF, 3'(s));

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'hEE, 3'd1);

        repeat (10) cycle(1'b1, 1'b1, 1'b0, 8'($urandom), 3'd3);
        for (int s = 0; s < 8; s++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 3'(s));

        cycle(1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 3'd3);
        cycle(1'b1, 1'b1, 1'b1, 8'h55, 3'd0);

        cycle(1'b1, 1'b1, 1'b0, 8'h11, 3'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'h22, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h3C, 3'd0);

        mid_reset();
        for (int s = 0; s < 4; s++) cycle(1'b0, 1'b1, 1'b0, 8'h77, 3'(s));
        cycle(1'b1, 1'b1, 1'b0, 8'h9A, 3'd0);

        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), 8'($urandom), 3'($urandom_range(0, 7)));
        end

        for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
